// File: rtl/video_scandbl.sv
// video_scandbl: two-bank line buffer that captures one TV-rate line
// and replays the opposite bank twice at VGA rate, with blank gating.
module video_scandbl #(
   parameter int DW = 16,
   parameter int AW = 10,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_stb,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_stb,
   input  logic [AW-1:0] rd_addr,
   input  logic          vga_blank,
   input  logic          coll_clr,
   output logic [DW-1:0] pix_out,
   output logic          blank_out,
   output logic [1:0]    bank_valid,
   output logic [CW-1:0] coll_cnt
);

   logic [DW-1:0] mem [2**AW];

   logic          wr_bank;
   logic [DW-1:0] ram_q;
   logic          blk1;
   logic          val1;

   logic wbank;
   logic rbank;
   logic wr_hit;
   logic flip;
   logic coll;

   assign wbank  = wr_addr[AW-1];
   assign rbank  = rd_addr[AW-1];
   assign wr_hit = wr_stb && wr_en;
   assign flip   = wr_stb && (wbank != wr_bank);
   assign coll   = wr_hit && rd_stb && (wbank == rbank);

   // Line RAM write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_hit)
         mem[wr_addr] <= wr_data;
   end

   // Bank tracker: a flip clears the new bank unless it is written now.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_bank    <= 1'b0;
         bank_valid <= 2'b00;
      end else if (flip) begin
         wr_bank           <= wbank;
         bank_valid[wbank] <= wr_en;
      end else if (wr_hit) begin
         bank_valid[wbank] <= 1'b1;
      end
   end

   // Read stage 1: RAM read (old data on same-address write), blank and valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ram_q <= '0;
         blk1  <= 1'b1;
         val1  <= 1'b0;
      end else if (rd_stb) begin
         ram_q <= mem[rd_addr];
         blk1  <= vga_blank;
         val1  <= bank_valid[rbank];
      end
   end

   // Read stage 2: zero the pixel when blanked or the bank holds no line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_out   <= '0;
         blank_out <= 1'b1;
      end else if (rd_stb) begin
         pix_out   <= (blk1 || !val1) ? '0 : ram_q;
         blank_out <= blk1;
      end
   end

   // Saturating collision counter; clear beats increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         coll_cnt <= '0;
      else if (coll_clr)
         coll_cnt <= '0;
      else if (coll && (coll_cnt != {CW{1'b1}}))
         coll_cnt <= coll_cnt + 1'b1;
   end

endmodule

// File: tb/tb_video_scandbl.sv
// tb_video_scandbl: directed checks of write/replay, blank gating,
// bank validity, read-before-write and collision counting.
module tb_video_scandbl;

   localparam int DW = 16;
   localparam int AW = 10;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          wr_stb;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          rd_stb;
   logic [AW-1:0] rd_addr;
   logic          vga_blank;
   logic          coll_clr;
   logic [DW-1:0] pix_out;
   logic          blank_out;
   logic [1:0]    bank_valid;
   logic [CW-1:0] coll_cnt;

   int nvec = 0;
   int nbad = 0;

   always #5 clk = ~clk;

   video_scandbl #(.DW(DW), .AW(AW), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_stb(wr_stb), .wr_en(wr_en),
      .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_stb(rd_stb), .rd_addr(rd_addr),
      .vga_blank(vga_blank), .coll_clr(coll_clr),
      .pix_out(pix_out), .blank_out(blank_out),
      .bank_valid(bank_valid), .coll_cnt(coll_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nbad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input bit bank, input int idx,
                     input logic [DW-1:0] d, input bit en);
      wr_stb  = 1'b1;
      wr_en   = en;
      wr_addr = {bank, 9'(idx)};
      wr_data = d;
      tick();
      wr_stb = 1'b0;
      wr_en  = 1'b0;
   endtask

   // Replay n pixels of a bank; index j carries 0x100+j when valid.
   task automatic rd_pass(input bit bank, input int n, input int bfrom,
                          input bit gap, input bit vld);
      logic [31:0] e;
      bit          bl;
      for (int i = 0; i <= n; i++) begin
         rd_stb    = 1'b1;
         rd_addr   = {bank, 9'(i < n ? i : 0)};
         vga_blank = (i >= bfrom) || (i >= n);
         tick();
         if (i >= 1) begin
            bl = (i - 1) >= bfrom;
            e  = (bl || !vld) ? 32'h0 : 32'(i - 1 + 'h100);
            chk("pix", 32'(pix_out), e);
            chk("blank", 32'(blank_out), 32'(bl));
         end
         if (gap) begin
            rd_stb    = 1'b0;
            rd_addr   = ~rd_addr;
            vga_blank = ~vga_blank;
            tick();
            if (i >= 1)
               chk("hold", 32'(pix_out), e);
         end
      end
      rd_stb    = 1'b0;
      vga_blank = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      wr_stb    = 1'b0;
      wr_en     = 1'b0;
      wr_addr   = '0;
      wr_data   = '0;
      rd_stb    = 1'b0;
      rd_addr   = '0;
      vga_blank = 1'b0;
      coll_clr  = 1'b0;

      // Strobes and colliding traffic while held in reset.
      wr_stb = 1'b1;
      wr_en  = 1'b1;
      rd_stb = 1'b1;
      wr_addr = 10'h200;
      rd_addr = 10'h200;
      for (int i = 0; i < 4; i++) tick();
      chk("rst_pix", 32'(pix_out), 32'h0);
      chk("rst_blank", 32'(blank_out), 32'h1);
      chk("rst_valid", 32'(bank_valid), 32'h0);
      chk("rst_coll", 32'(coll_cnt), 32'h0);
      wr_stb = 1'b0;
      wr_en  = 1'b0;
      rd_stb = 1'b0;
      rst_n  = 1'b1;
      tick();

      // Fill bank 0, then flip to bank 1 without writing.
      for (int i = 0; i < 360; i++)
         wr(1'b0, i, 16'(i + 'h100), 1'b1);
      chk("fill_valid", 32'(bank_valid), 32'h1);
      wr(1'b1, 0, 16'h0, 1'b0);
      chk("flip_valid", 32'(bank_valid), 32'h1);

      // Replay bank 0 twice, second pass with idle gaps.
      rd_pass(1'b0, 360, 360, 1'b0, 1'b1);
      rd_pass(1'b0, 360, 360, 1'b1, 1'b1);
      // Blanked tail from index 360.
      rd_pass(1'b0, 400, 360, 1'b0, 1'b1);
      chk("no_coll", 32'(coll_cnt), 32'h0);

      // Stale data in bank 1 must read as zero after reset.
      for (int i = 0; i < 11; i++)
         wr(1'b1, i, 16'(i + 'h100), 1'b1);
      chk("b1_valid", 32'(bank_valid), 32'h3);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      chk("rst2_valid", 32'(bank_valid), 32'h0);
      rd_pass(1'b1, 11, 11, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++)
         wr(1'b1, i, 16'h5555, 1'b0);
      chk("noen_valid", 32'(bank_valid), 32'h0);

      // Saturating collisions in bank 0.
      wr_stb = 1'b1;
      wr_en  = 1'b1;
      rd_stb = 1'b1;
      rd_addr = 10'h0;
      for (int i = 0; i < 300; i++) begin
         wr_addr = 10'(i % 512);
         wr_data = 16'(i);
         tick();
         if (i == 253)
            chk("coll_254", 32'(coll_cnt), 32'd254);
      end
      chk("coll_sat", 32'(coll_cnt), 32'd255);
      coll_clr = 1'b1;
      tick();
      chk("coll_clr", 32'(coll_cnt), 32'h0);
      coll_clr = 1'b0;
      tick();
      chk("coll_one", 32'(coll_cnt), 32'h1);
      wr_stb = 1'b0;
      wr_en  = 1'b0;
      rd_stb = 1'b0;
      chk("race_pre", 32'(bank_valid), 32'h1);

      // Flip with write sets the new bank; flip without clears it.
      wr(1'b1, 0, 16'h1111, 1'b1);
      chk("race_set", 32'(bank_valid), 32'h3);
      wr(1'b0, 0, 16'h0, 1'b0);
      chk("race_clr", 32'(bank_valid), 32'h2);

      // Same-address write and read returns the old word.
      wr(1'b1, 5, 16'h1111, 1'b1);
      rd_stb    = 1'b1;
      vga_blank = 1'b0;
      rd_addr   = 10'h205;
      wr_stb    = 1'b1;
      wr_en     = 1'b1;
      wr_addr   = 10'h205;
      wr_data   = 16'h2222;
      tick();
      wr_stb = 1'b0;
      wr_en  = 1'b0;
      tick();
      chk("rbw_old", 32'(pix_out), 32'h1111);
      chk("rbw_coll", 32'(coll_cnt), 32'h2);
      tick();
      chk("rbw_new", 32'(pix_out), 32'h2222);
      rd_stb = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
